// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage parametrised floating-point adder/subtractor with
// valid/ready flow control, round-to-nearest-even and special-value handling.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_ovf,
  output logic                 out_nan
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned MW   = MAN_W + 4;          // hidden + frac + G/R/S
  localparam int unsigned EW2  = EXP_W + 2;          // headroom for carry/round
  localparam int unsigned RW   = MAN_W + 2;
  localparam int unsigned LZ_W = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  // One global advance: every stage moves together or holds, bubbles included.
  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = LZ_W'(MW);
    found = 1'b0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZ_W'(int'(MW) - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb, w_el, w_es, w_ediff;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic [MAN_W:0]   w_ma, w_mb, w_ml, w_ms;
  logic             w_sl, w_swap;
  logic [2*MW-1:0]  w_shift;
  logic [MW-1:0]    w_small;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_spec, w_spec_nan;
  logic [W-1:0]     w_spec_res;

  always_comb begin
    w_sa   = in_a[W-1];
    w_ea   = in_a[W-2 -: EXP_W];
    w_fa   = in_a[MAN_W-1:0];
    w_sb   = in_b[W-1] ^ in_sub;
    w_eb   = in_b[W-2 -: EXP_W];
    w_fb   = in_b[MAN_W-1:0];
    w_ma   = (w_ea == '0) ? '0 : {1'b1, w_fa};
    w_mb   = (w_eb == '0) ? '0 : {1'b1, w_fb};
    w_swap = {w_eb, w_mb} > {w_ea, w_ma};
    if (w_swap) begin
      w_sl = w_sb; w_el = w_eb; w_ml = w_mb; w_es = w_ea; w_ms = w_ma;
    end else begin
      w_sl = w_sa; w_el = w_ea; w_ml = w_ma; w_es = w_eb; w_ms = w_mb;
    end
    w_ediff = w_el - w_es;
    w_shift = {w_ms, 3'b000, {MW{1'b0}}} >> w_ediff;
    if (32'(w_ediff) >= MW) begin
      w_small = {{(MW-1){1'b0}}, |w_ms};
    end else begin
      w_small = {w_shift[2*MW-1:MW+1], w_shift[MW] | (|w_shift[MW-1:0])};
    end
    w_a_nan    = (w_ea == EXP_MAX) && (w_fa != '0);
    w_b_nan    = (w_eb == EXP_MAX) && (w_fb != '0);
    w_a_inf    = (w_ea == EXP_MAX) && (w_fa == '0);
    w_b_inf    = (w_eb == EXP_MAX) && (w_fb == '0);
    w_spec     = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
    w_spec_nan = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb));
    if (w_spec_nan)   w_spec_res = QNAN;
    else if (w_a_inf) w_spec_res = {w_sa, EXP_MAX, {MAN_W{1'b0}}};
    else              w_spec_res = {w_sb, EXP_MAX, {MAN_W{1'b0}}};
  end

  logic             r1_valid, r1_sign, r1_eff_sub, r1_spec, r1_nan;
  logic [EXP_W-1:0] r1_exp;
  logic [MW-1:0]    r1_ml, r1_ms;
  logic [W-1:0]     r1_spec_res;
  logic [TAG_W-1:0] r1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r1_sign     <= 1'b0;
      r1_eff_sub  <= 1'b0;
      r1_spec     <= 1'b0;
      r1_nan      <= 1'b0;
      r1_exp      <= '0;
      r1_ml       <= '0;
      r1_ms       <= '0;
      r1_spec_res <= '0;
      r1_tag      <= '0;
    end else if (w_en) begin
      r1_valid    <= in_valid;
      r1_sign     <= w_sl;
      r1_eff_sub  <= w_sa ^ w_sb;
      r1_spec     <= w_spec;
      r1_nan      <= w_spec_nan;
      r1_exp      <= w_el;
      r1_ml       <= {w_ml, 3'b000};
      r1_ms       <= w_small;
      r1_spec_res <= w_spec_res;
      r1_tag      <= in_tag;
    end
  end

  // ---------------- Stage 2: add/subtract and normalise ----------------
  logic [MW:0]      w_sum;
  logic [MW-1:0]    w_diff, w_norm, w_mant2;
  logic [LZ_W-1:0]  w_lz;
  logic [EW2-1:0]   w_exp2;
  logic             w_sign2, w_zero2;

  always_comb begin
    w_sum   = {1'b0, r1_ml} + {1'b0, r1_ms};
    w_diff  = r1_ml - r1_ms;
    w_lz    = lzc(w_diff);
    w_norm  = w_diff << w_lz;
    w_sign2 = r1_sign;
    w_exp2  = EW2'(r1_exp);
    w_mant2 = '0;
    w_zero2 = 1'b0;
    if (!r1_eff_sub) begin
      if (w_sum[MW]) begin
        w_mant2 = {w_sum[MW:2], w_sum[1] | w_sum[0]};
        w_exp2  = EW2'(r1_exp) + EW2'(1);
      end else begin
        w_mant2 = w_sum[MW-1:0];
      end
      w_zero2 = (w_sum == '0);
    end else if (w_diff == '0) begin
      w_zero2 = 1'b1;
      w_sign2 = 1'b0;
    end else begin
      w_mant2 = w_norm;
      if (32'(r1_exp) <= 32'(w_lz)) w_zero2 = 1'b1;
      else                          w_exp2  = EW2'(r1_exp) - EW2'(w_lz);
    end
  end

  logic             r2_valid, r2_sign, r2_zero, r2_spec, r2_nan;
  logic [EW2-1:0]   r2_exp;
  logic [MW-1:0]    r2_mant;
  logic [W-1:0]     r2_spec_res;
  logic [TAG_W-1:0] r2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid    <= 1'b0;
      r2_sign     <= 1'b0;
      r2_zero     <= 1'b0;
      r2_spec     <= 1'b0;
      r2_nan      <= 1'b0;
      r2_exp      <= '0;
      r2_mant     <= '0;
      r2_spec_res <= '0;
      r2_tag      <= '0;
    end else if (w_en) begin
      r2_valid    <= r1_valid;
      r2_sign     <= w_sign2;
      r2_zero     <= w_zero2;
      r2_spec     <= r1_spec;
      r2_nan      <= r1_nan;
      r2_exp      <= w_exp2;
      r2_mant     <= w_mant2;
      r2_spec_res <= r1_spec_res;
      r2_tag      <= r1_tag;
    end
  end

  // ---------------- Stage 3: round to nearest even and pack ----------------
  logic             w_inc, w_ovf3;
  logic [RW-1:0]    w_rnd;
  logic [EW2-1:0]   w_exp3;
  logic [MAN_W-1:0] w_frac3;
  logic [W-1:0]     w_res3;

  always_comb begin
    w_inc   = r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
    w_rnd   = {1'b0, r2_mant[MW-1:3]} + RW'(w_inc);
    w_exp3  = r2_exp;
    w_frac3 = w_rnd[MAN_W-1:0];
    w_ovf3  = 1'b0;
    if (w_rnd[MAN_W+1]) begin
      w_exp3  = r2_exp + EW2'(1);
      w_frac3 = '0;
    end
    if (r2_spec) begin
      w_res3 = r2_spec_res;
    end else if (r2_zero) begin
      w_res3 = {r2_sign, {(W-1){1'b0}}};
    end else if (w_exp3 >= EW2'(EXP_MAX)) begin
      w_res3 = {r2_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_ovf3 = 1'b1;
    end else begin
      w_res3 = {r2_sign, w_exp3[EXP_W-1:0], w_frac3};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_ovf    <= 1'b0;
      out_nan    <= 1'b0;
    end else if (w_en) begin
      out_valid  <= r2_valid;
      out_result <= w_res3;
      out_tag    <= r2_tag;
      out_ovf    <= w_ovf3;
      out_nan    <= r2_nan;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (single precision): directed vectors,
// backpressure and reset scenarios, plus random ops against an exact-arithmetic model.
module tb_fp_addsub_pipe;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_ovf, out_nan;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ovf;
    logic        nan;
  } sb_t;

  sb_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0000, 32'h7F7F_FFFF, 32'h0000_0001, 32'h0080_0000};

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_ovf(out_ovf), .out_nan(out_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation still running (got hang, want finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Exact value as an integer in units of the smallest normal ulp, then round once.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
    logic         sa, sb, sr, a_nan, b_nan, a_inf, b_inf;
    int           ea, eb, p, s, e;
    logic [22:0]  fa, fb;
    logic [299:0] na, nb, mag, q, rem, half;
    sa = a[31]; ea = int'(a[30:23]); fa = a[22:0];
    sb = b[31] ^ sub; eb = int'(b[30:23]); fb = b[22:0];
    a_nan = (ea == 255) && (fa != 0);
    b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0);
    b_inf = (eb == 255) && (fb == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return {2'b10, 32'h7FC0_0000};
    if (a_inf) return {2'b00, sa, 8'hFF, 23'h0};
    if (b_inf) return {2'b00, sb, 8'hFF, 23'h0};
    na = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
    nb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
    if (sa == sb)      begin mag = na + nb; sr = sa; end
    else if (na >= nb) begin mag = na - nb; sr = sa; end
    else               begin mag = nb - na; sr = sb; end
    if (mag == 0) return {2'b00, (sa == sb) ? sa : 1'b0, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {2'b00, sr, 31'h0};
    s = p - 23;
    q = mag >> s;
    if (s > 0) begin
      rem  = mag & ((300'(1) << s) - 1);
      half = 300'(1) << (s - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    end
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {2'b01, sr, 8'hFF, 23'h0};
    return {2'b00, sr, 8'(e), q[22:0]};
  endfunction

  task automatic gen_op(output logic [31:0] a, output logic [31:0] b, output logic sub);
    logic [31:0] r;
    a   = $urandom;
    b   = $urandom;
    sub = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      1, 2: b[30:23] = a[30:23] - 8'($urandom_range(0, 3));
      3:    b[30:23] = a[30:23] - 8'($urandom_range(20, 30));
      4:    b = a ^ 32'($urandom_range(0, 7));
      5: begin
        a[30:23] = 8'($urandom_range(250, 254));
        b[30:23] = 8'($urandom_range(250, 254));
      end
      6: begin
        a[30:23] = 8'($urandom_range(1, 3));
        b[30:23] = 8'($urandom_range(1, 3));
      end
      7: begin
        r = specials[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) a = r; else b = r;
      end
      default: ;
    endcase
  endtask

  // One op into an idle pipe with out_ready high; checks latency and contents.
  task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [3:0] tag, input logic [31:0] want,
                        input logic want_ovf, input logic want_nan);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_lat"}, n, 3);
    check({name, "_res"}, out_result, want);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    check({name, "_ovf"}, 32'(out_ovf), 32'(want_ovf));
    check({name, "_nan"}, 32'(out_nan), 32'(want_nan));
    @(posedge clk); #1;
  endtask

  // mode 0: always offer, out_ready pattern 1,0,0,1; mode 1: random valid/ready.
  task automatic run_stream(input int n_ops, input int mode);
    int          sent, got, cyc;
    logic        accepted, hold_v, cur_sub;
    logic [31:0] hold_res, cur_a, cur_b;
    logic [3:0]  hold_tag, cur_tag;
    logic [33:0] m;
    sb_t         e;
    sent = 0; got = 0; cyc = 0; accepted = 1'b0; hold_v = 1'b0;
    hold_res = '0; hold_tag = '0; cur_a = '0; cur_b = '0; cur_sub = 1'b0; cur_tag = '0;
    in_valid = 1'b0;
    while ((got < n_ops) && (cyc < n_ops * 20 + 200)) begin
      if (!in_valid || accepted) begin
        if ((sent < n_ops) && ((mode == 0) || ($urandom_range(0, 3) != 0))) begin
          gen_op(cur_a, cur_b, cur_sub);
          cur_tag = 4'(sent);
          in_a = cur_a; in_b = cur_b; in_sub = cur_sub; in_tag = cur_tag; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (mode == 0) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else           out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (hold_v) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_res", out_result, hold_res);
        check("hold_tag", 32'(out_tag), 32'(hold_tag));
      end
      hold_v = out_valid && !out_ready;
      if (hold_v) begin
        hold_res = out_result;
        hold_tag = out_tag;
        check("stall_in_ready", 32'(in_ready), 32'(0));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check($sformatf("op%0d_res a=%h b=%h", got, cur_a, cur_b), out_result, e.res);
          check($sformatf("op%0d_tag", got), 32'(out_tag), 32'(e.tag));
          check($sformatf("op%0d_ovf", got), 32'(out_ovf), 32'(e.ovf));
          check($sformatf("op%0d_nan", got), 32'(out_nan), 32'(e.nan));
          got++;
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        m = ref_add(cur_a, cur_b, cur_sub);
        sb_q.push_back('{res: m[31:0], tag: cur_tag, ovf: m[32], nan: m[33]});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, n_ops);
    check("stream_drained", 32'(out_valid), 32'(0));
    check("stream_sb_empty", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'(0));
    check("rst_out_ovf", 32'(out_ovf), 32'(0));
    check("rst_out_nan", 32'(out_nan), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    single("add_1p2",   32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5, 32'h4040_0000, 1'b0, 1'b0);
    single("cancel",    32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 4'd1, 32'h0000_0000, 1'b0, 1'b0);
    single("sub_1m3",   32'h3F80_0000, 32'h4040_0000, 1'b1, 4'd2, 32'hC000_0000, 1'b0, 1'b0);
    single("rne_tie_e", 32'h3F80_0000, 32'h3380_0000, 1'b0, 4'd3, 32'h3F80_0000, 1'b0, 1'b0);
    single("rne_tie_o", 32'h3F80_0001, 32'h3380_0000, 1'b0, 4'd4, 32'h3F80_0002, 1'b0, 1'b0);
    single("ovf",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd6, 32'h7F80_0000, 1'b1, 1'b0);
    single("inf_m_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd7, 32'h7FC0_0000, 1'b0, 1'b1);
    single("denorm",    32'h0000_0001, 32'h3F80_0000, 1'b0, 4'd8, 32'h3F80_0000, 1'b0, 1'b0);
    single("negzero",   32'h8000_0000, 32'h8000_0000, 1'b0, 4'd9, 32'h8000_0000, 1'b0, 1'b0);
    single("inf_fin",   32'h3F80_0000, 32'hFF80_0000, 1'b0, 4'hA, 32'hFF80_0000, 1'b0, 1'b0);
    single("nan_in",    32'hFF80_0001, 32'h3F80_0000, 1'b1, 4'hB, 32'h7FC0_0000, 1'b0, 1'b1);
    single("far_sub",   32'h3F80_0000, 32'h3280_0000, 1'b1, 4'hC, 32'h3F80_0000, 1'b0, 1'b0);
    single("one_m_ulp", 32'h3F80_0000, 32'h3380_0000, 1'b1, 4'hD, 32'h3F7F_FFFF, 1'b0, 1'b0);

    run_stream(8, 0);
    run_stream(2000, 1);

    // Three ops in flight, then an asynchronous reset between clock edges.
    sb_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_sub = 1'b0; in_tag = 4'(i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'(0));
    check("async_rst_result", out_result, 32'h0);
    check("async_rst_tag", 32'(out_tag), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'(0));
    end
    single("post_rst", 32'h4000_0000, 32'h4000_0000, 1'b0, 4'hE, 32'h4080_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
